// File: rtl/sa_result_collector_pkg.sv
// sa_result_collector_pkg: shared FSM encoding and default sizes for the SA result collector
package sa_result_collector_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_COLLECT = 3'b010,
    S_HOLD    = 3'b100
  } state_e;
  localparam int D_W_DEF     = 16;
  localparam int ACC_W_DEF   = 32;
  localparam int X_R_DEF     = 16;
  localparam int W_C_DEF     = 16;
  localparam int FRAC_SH_DEF = 8;
endpackage

// File: rtl/sa_round_sat.sv
// sa_round_sat: rescales one signed accumulator to D_W bits with round-half-up shift and signed saturation
module sa_round_sat #(
  parameter int ACC_W   = 32,
  parameter int D_W     = 16,
  parameter int FRAC_SH = 8
) (
  input  logic [ACC_W-1:0] acc,
  output logic [D_W-1:0]   q,
  output logic             sat
);
  localparam logic [ACC_W:0]        ONE = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] RND = (ONE << FRAC_SH) >> 1;
  localparam logic signed [ACC_W:0] MAX = {{(ACC_W-D_W+2){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN = {{(ACC_W-D_W+2){1'b1}}, {(D_W-1){1'b0}}};
  logic signed [ACC_W:0] sh;
  logic hi, lo;
  assign sh  = ($signed({acc[ACC_W-1], acc}) + RND) >>> FRAC_SH;
  assign hi  = sh > MAX;
  assign lo  = sh < MIN;
  assign sat = hi | lo;
  assign q   = hi ? MAX[D_W-1:0] : lo ? MIN[D_W-1:0] : sh[D_W-1:0];
endmodule

// File: rtl/sa_result_collector.sv
// sa_result_collector: captures SA result rows, rescales them and holds the packed matrix behind a valid/ready handshake
module sa_result_collector
  import sa_result_collector_pkg::*;
#(
  parameter int D_W     = D_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int X_R     = X_R_DEF,
  parameter int W_C     = W_C_DEF,
  parameter int FRAC_SH = FRAC_SH_DEF
) (
  input  logic                   I_CLK,
  input  logic                   I_ASYN_RSTN,
  input  logic                   I_SYNC_RSTN,
  input  logic                   I_START,
  input  logic                   I_ROW_VLD,
  input  logic [W_C*ACC_W-1:0]   I_ROW_VECTOR,
  input  logic                   I_MAT_RDY,
  output logic                   O_BUSY,
  output logic                   O_MAT_VLD,
  output logic [X_R*W_C*D_W-1:0] O_MATRIX,
  output logic                   O_SAT,
  output logic                   O_ERR
);
  localparam int CNT_W = $clog2(X_R+1);
  localparam int ROW_W = W_C*D_W;
  state_e state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic vld_q, vld_d, sat_q, sat_d, err_q, err_d, wr, last;
  logic [ROW_W-1:0] row;
  logic [W_C-1:0] row_sat;
  logic [X_R*ROW_W-1:0] mat_q;
  for (genvar c = 0; c < W_C; c++) begin : g_col
    sa_round_sat #(.ACC_W(ACC_W), .D_W(D_W), .FRAC_SH(FRAC_SH)) u_rs (
      .acc(I_ROW_VECTOR[c*ACC_W +: ACC_W]),
      .q  (row[c*D_W +: D_W]),
      .sat(row_sat[c])
    );
  end
  assign last = row_cnt_q == CNT_W'(X_R-1);
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    vld_d     = vld_q;
    sat_d     = sat_q;
    err_d     = err_q;
    wr        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        err_d = err_q | I_ROW_VLD;
        if (I_START) begin
          state_d   = S_COLLECT;
          row_cnt_d = '0;
          sat_d     = 1'b0;
        end
      end
      S_COLLECT: if (I_ROW_VLD) begin
        wr        = 1'b1;
        row_cnt_d = row_cnt_q + CNT_W'(1);
        sat_d     = sat_q | (|row_sat);
        state_d   = last ? S_HOLD : S_COLLECT;
        vld_d     = last;
      end
      S_HOLD: begin
        err_d = err_q | I_ROW_VLD;
        if (I_MAT_RDY) begin
          vld_d   = 1'b0;
          state_d = I_START ? S_COLLECT : S_IDLE;
          if (I_START) begin
            row_cnt_d = '0;
            sat_d     = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!I_SYNC_RSTN) begin
      state_d   = S_IDLE;
      row_cnt_d = '0;
      vld_d     = 1'b0;
      sat_d     = 1'b0;
      err_d     = 1'b0;
      wr        = 1'b0;
    end
  end
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      vld_q     <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      vld_q     <= vld_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
    end
  end
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) mat_q <= '0;
    else if (!I_SYNC_RSTN) mat_q <= '0;
    else for (int r = 0; r < X_R; r++) if (wr && row_cnt_q == CNT_W'(r)) mat_q[r*ROW_W +: ROW_W] <= row;
  end
  assign O_BUSY    = state_q != S_IDLE;
  assign O_MAT_VLD = vld_q;
  assign O_MATRIX  = mat_q;
  assign O_SAT     = sat_q;
  assign O_ERR     = err_q;
endmodule

// File: tb/tb_sa_result_collector.sv
// tb_sa_result_collector: randomized self-checking bench against an arithmetic model of rescale and collection
module tb_sa_result_collector;
  localparam int D_W = 16, ACC_W = 32, X_R = 4, W_C = 4, FRAC_SH = 8;
  logic I_CLK = 1'b0, I_ASYN_RSTN = 1'b0, I_SYNC_RSTN = 1'b1;
  logic I_START = 1'b0, I_ROW_VLD = 1'b0, I_MAT_RDY = 1'b0;
  logic [W_C*ACC_W-1:0] I_ROW_VECTOR = '0;
  logic O_BUSY, O_MAT_VLD, O_SAT, O_ERR;
  logic [X_R*W_C*D_W-1:0] O_MATRIX;
  int checks = 0, failures = 0;
  longint acc_m [X_R][W_C];
  logic [X_R*W_C*D_W-1:0] exp_mat = '0;
  logic exp_sat = 1'b0;
  sa_result_collector #(.D_W(D_W), .ACC_W(ACC_W), .X_R(X_R), .W_C(W_C), .FRAC_SH(FRAC_SH)) dut (
    .I_CLK(I_CLK), .I_ASYN_RSTN(I_ASYN_RSTN), .I_SYNC_RSTN(I_SYNC_RSTN), .I_START(I_START),
    .I_ROW_VLD(I_ROW_VLD), .I_ROW_VECTOR(I_ROW_VECTOR), .I_MAT_RDY(I_MAT_RDY),
    .O_BUSY(O_BUSY), .O_MAT_VLD(O_MAT_VLD), .O_MATRIX(O_MATRIX), .O_SAT(O_SAT), .O_ERR(O_ERR)
  );
  always #5 I_CLK = ~I_CLK;
  function automatic logic [16:0] model(input longint a);
    longint r;
    r = (a + 128) >>> FRAC_SH;
    if (r > 32767) return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction
  function automatic longint rnd_acc(input int sh);
    return longint'(int'($urandom)) >>> sh;
  endfunction
  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask
  task automatic run_collect(input bit do_start, input int max_gap, input bit start_noise);
    logic [W_C*ACC_W-1:0] vec;
    logic [16:0] m;
    longint a;
    int gap;
    exp_sat = 1'b0;
    if (do_start) begin
      I_START = 1'b1;
      tick();
      I_START = 1'b0;
      checks++;
      if (O_BUSY !== 1'b1) begin failures++; $display("FAIL start_busy: got %b expected 1", O_BUSY); end
    end
    for (int r = 0; r < X_R; r++) begin
      for (int c = 0; c < W_C; c++) begin
        a = acc_m[r][c];
        vec[c*ACC_W +: ACC_W] = a[31:0];
        m = model(a);
        exp_mat[(r*W_C+c)*D_W +: D_W] = m[15:0];
        exp_sat |= m[16];
      end
      gap = max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        I_START = start_noise ? 1'($urandom) : 1'b0;
        tick();
      end
      I_START = 1'b0;
      I_ROW_VLD = 1'b1;
      I_ROW_VECTOR = vec;
      tick();
      I_ROW_VLD = 1'b0;
      checks++;
      if (O_MAT_VLD !== (r == X_R-1)) begin
        failures++;
        $display("FAIL mat_vld_row%0d: got %b expected %b", r, O_MAT_VLD, r == X_R-1);
      end
    end
    checks++;
    if (O_MATRIX !== exp_mat) begin failures++; $display("FAIL matrix: got %h expected %h", O_MATRIX, exp_mat); end
    checks++;
    if (O_SAT !== exp_sat || O_BUSY !== 1'b1) begin
      failures++;
      $display("FAIL sat_busy: got sat=%b busy=%b expected sat=%b busy=1", O_SAT, O_BUSY, exp_sat);
    end
  endtask
  task automatic handshake();
    I_MAT_RDY = 1'b1;
    tick();
    I_MAT_RDY = 1'b0;
    checks++;
    if (O_MAT_VLD !== 1'b0 || O_BUSY !== 1'b0 || O_MATRIX !== exp_mat) begin
      failures++;
      $display("FAIL handshake: got vld=%b busy=%b mat=%h expected vld=0 busy=0 mat=%h", O_MAT_VLD, O_BUSY, O_MATRIX, exp_mat);
    end
  endtask
  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({O_BUSY, O_MAT_VLD, O_SAT, O_ERR} !== 4'b0 || O_MATRIX !== '0) begin
      failures++;
      $display("FAIL reset: got busy/vld/sat/err=%b mat=%h expected 0000 and 0", {O_BUSY, O_MAT_VLD, O_SAT, O_ERR}, O_MATRIX);
    end
    I_ASYN_RSTN = 1'b1;
    tick();
  endtask
  task automatic set_basic();
    for (int r = 0; r < X_R; r++) for (int c = 0; c < W_C; c++) acc_m[r][c] = longint'((r*W_C+c) << FRAC_SH);
  endtask
  task automatic test_basic();
    set_basic();
    run_collect(1'b1, 0, 1'b0);
    checks++;
    if (O_MATRIX[(1*W_C+2)*D_W +: D_W] !== 16'd6 || O_MATRIX[(3*W_C+3)*D_W +: D_W] !== 16'd15) begin
      failures++;
      $display("FAIL basic_elem: got %h %h expected 0006 000f", O_MATRIX[(1*W_C+2)*D_W +: D_W], O_MATRIX[(3*W_C+3)*D_W +: D_W]);
    end
    handshake();
  endtask
  task automatic test_rounding();
    for (int r = 0; r < X_R; r++) for (int c = 0; c < W_C; c++) acc_m[r][c] = rnd_acc(9);
    acc_m[0][0] = 'h180;
    acc_m[0][1] = 'h17f;
    acc_m[0][2] = -'h180;
    acc_m[0][3] = -'h181;
    run_collect(1'b1, 0, 1'b0);
    checks++;
    if (O_MATRIX[63:0] !== 64'hfffe_ffff_0001_0002) begin
      failures++;
      $display("FAIL rounding: got %h expected fffeffff00010002", O_MATRIX[63:0]);
    end
    handshake();
  endtask
  task automatic test_saturation();
    for (int r = 0; r < X_R; r++) for (int c = 0; c < W_C; c++) acc_m[r][c] = rnd_acc(0);
    acc_m[0][0] = 'h7fffffff;
    acc_m[0][1] = -'h80000000;
    acc_m[0][2] = 'h7fff80;
    acc_m[0][3] = 'h7fff7f;
    run_collect(1'b1, 0, 1'b0);
    checks++;
    if (O_MATRIX[63:0] !== 64'h7fff_7fff_8000_7fff || O_SAT !== 1'b1) begin
      failures++;
      $display("FAIL saturation: got %h sat=%b expected 7fff7fff80007fff sat=1", O_MATRIX[63:0], O_SAT);
    end
  endtask
  task automatic test_hold();
    checks++;
    if (O_ERR !== 1'b0) begin failures++; $display("FAIL err_before_hold: got %b expected 0", O_ERR); end
    for (int i = 0; i < 20; i++) begin
      I_ROW_VLD = (i == 0) ? 1'b1 : 1'($urandom);
      I_ROW_VECTOR = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (O_MATRIX !== exp_mat || O_MAT_VLD !== 1'b1 || O_SAT !== exp_sat) begin
        failures++;
        $display("FAIL hold_cycle%0d: got vld=%b sat=%b mat=%h expected vld=1 sat=%b mat=%h", i, O_MAT_VLD, O_SAT, O_MATRIX, exp_sat, exp_mat);
      end
    end
    I_ROW_VLD = 1'b0;
    checks++;
    if (O_ERR !== 1'b1) begin failures++; $display("FAIL hold_err: got %b expected 1", O_ERR); end
    I_MAT_RDY = 1'b1;
    I_START = 1'b1;
    tick();
    I_MAT_RDY = 1'b0;
    I_START = 1'b0;
    checks++;
    if (O_BUSY !== 1'b1 || O_MAT_VLD !== 1'b0 || O_SAT !== 1'b0) begin
      failures++;
      $display("FAIL rdy_start: got busy=%b vld=%b sat=%b expected 1 0 0", O_BUSY, O_MAT_VLD, O_SAT);
    end
    for (int r = 0; r < X_R; r++) for (int c = 0; c < W_C; c++) acc_m[r][c] = rnd_acc(8);
    run_collect(1'b0, 2, 1'b0);
    handshake();
  endtask
  task automatic test_async_reset();
    logic [W_C*ACC_W-1:0] vec;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    repeat (2) begin
      for (int c = 0; c < W_C; c++) vec[c*ACC_W +: ACC_W] = $urandom;
      I_ROW_VLD = 1'b1;
      I_ROW_VECTOR = vec;
      tick();
    end
    I_ROW_VLD = 1'b0;
    I_ASYN_RSTN = 1'b0;
    #2;
    checks++;
    if ({O_BUSY, O_MAT_VLD, O_SAT, O_ERR} !== 4'b0 || O_MATRIX !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy/vld/sat/err=%b mat=%h expected 0000 and 0", {O_BUSY, O_MAT_VLD, O_SAT, O_ERR}, O_MATRIX);
    end
    tick();
    tick();
    I_ASYN_RSTN = 1'b1;
    tick();
    exp_mat = '0;
    for (int r = 0; r < X_R; r++) for (int c = 0; c < W_C; c++) acc_m[r][c] = rnd_acc(6);
    run_collect(1'b1, 0, 1'b0);
    handshake();
  endtask
  task automatic test_sync_reset();
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    I_ROW_VLD = 1'b1;
    I_ROW_VECTOR = {4{32'h0000_1200}};
    tick();
    I_ROW_VLD = 1'b0;
    I_SYNC_RSTN = 1'b0;
    tick();
    I_SYNC_RSTN = 1'b1;
    checks++;
    if ({O_BUSY, O_MAT_VLD, O_SAT, O_ERR} !== 4'b0 || O_MATRIX !== '0) begin
      failures++;
      $display("FAIL sync_reset: got busy/vld/sat/err=%b mat=%h expected 0000 and 0", {O_BUSY, O_MAT_VLD, O_SAT, O_ERR}, O_MATRIX);
    end
    exp_mat = '0;
  endtask
  task automatic test_idle_err();
    I_ROW_VLD = 1'b1;
    I_ROW_VECTOR = {4{32'h0000_5500}};
    tick();
    I_ROW_VLD = 1'b0;
    checks++;
    if (O_ERR !== 1'b1 || O_BUSY !== 1'b0 || O_MATRIX !== exp_mat) begin
      failures++;
      $display("FAIL idle_err: got err=%b busy=%b mat=%h expected err=1 busy=0 mat=%h", O_ERR, O_BUSY, O_MATRIX, exp_mat);
    end
  endtask
  task automatic test_gaps();
    set_basic();
    run_collect(1'b1, 5, 1'b1);
    handshake();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_hold();
    test_async_reset();
    test_sync_reset();
    test_idle_err();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
